// File: rtl/core_pkg.sv
// Shared definitions for the 8085-style core: bus widths and the
// machine-cycle / T-state codes used by core_fetch_seq.
package core_pkg;

  localparam int DEF_DATASIZE = 8;
  localparam int DEF_ADDRSIZE = 16;

  // Codes 13..15 are unused; the sequencer falls back to RESET from them.
  typedef enum logic [3:0] {
    RESET = 4'd0,
    OF_T1 = 4'd1,
    OF_T2 = 4'd2,
    OF_T3 = 4'd3,
    OF_T4 = 4'd4,
    OF_TW = 4'd5,
    MR_T1 = 4'd6,
    MR_T2 = 4'd7,
    MR_T3 = 4'd8,
    MR_TW = 4'd9,
    EX_RR = 4'd10,
    EX_WR = 4'd11,
    HALT  = 4'd12
  } state_t;

endpackage

// File: rtl/core_fetch_seq.sv
// Machine-cycle / T-state sequencer: fetches opcode and optional immediate
// byte, then strobes register read/write in the downstream ALU/register stage.
module core_fetch_seq
  import core_pkg::*;
#(
  parameter int DATASIZE = DEF_DATASIZE,
  parameter int ADDRSIZE = DEF_ADDRSIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ready,
  input  logic [ADDRSIZE-1:0] pc,
  input  logic                need_imm,
  input  logic                is_halt,
  output logic [ADDRSIZE-1:0] addr,
  output logic                ale,
  output logic                rd_n,
  output logic                enb_c,
  output logic                enb_d,
  output logic                enbrr,
  output logic                enbwr,
  output logic                pc_inc,
  output logic                halted,
  output logic [3:0]          state
);

  // Data bus lives in the downstream stage; the width is carried for a
  // uniform parameter set across the core.
  if (DATASIZE > 0) begin : g_datasize_ok
  end

  state_t              state_reg;
  state_t              state_next;
  logic [ADDRSIZE-1:0] addr_reg;

  // addr captures pc on the edge that enters a T1 and holds until the next T1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RESET;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next == OF_T1 || state_next == MR_T1)
        addr_reg <= pc;
    end
  end

  always_comb begin
    state_next = RESET;
    case (state_reg)
      RESET:        state_next = OF_T1;
      OF_T1:        state_next = OF_T2;
      OF_T2, OF_TW: state_next = ready ? OF_T3 : OF_TW;
      OF_T3:        state_next = OF_T4;
      OF_T4: begin
        if (is_halt)       state_next = HALT;
        else if (need_imm) state_next = MR_T1;
        else               state_next = EX_RR;
      end
      MR_T1:        state_next = MR_T2;
      MR_T2, MR_TW: state_next = ready ? MR_T3 : MR_TW;
      MR_T3:        state_next = EX_RR;
      EX_RR:        state_next = EX_WR;
      EX_WR:        state_next = OF_T1;
      HALT:         state_next = HALT;
      default:      state_next = RESET;
    endcase
  end

  // Moore decode: strobes depend on the state register only.
  always_comb begin
    ale    = 1'b0;
    rd_n   = 1'b1;
    enb_c  = 1'b0;
    enb_d  = 1'b0;
    enbrr  = 1'b0;
    enbwr  = 1'b0;
    pc_inc = 1'b0;
    halted = 1'b0;
    case (state_reg)
      OF_T1, MR_T1:               ale = 1'b1;
      OF_T2, OF_TW, MR_T2, MR_TW: rd_n = 1'b0;
      OF_T3: begin
        rd_n   = 1'b0;
        enb_c  = 1'b1;
        pc_inc = 1'b1;
      end
      MR_T3: begin
        rd_n   = 1'b0;
        enb_d  = 1'b1;
        pc_inc = 1'b1;
      end
      EX_RR: enbrr = 1'b1;
      EX_WR: begin
        enbrr = 1'b1;
        enbwr = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  assign addr  = addr_reg;
  assign state = state_reg;

endmodule

// File: tb/tb_core_fetch_seq.sv
// Bench for core_fetch_seq: builds the expected per-cycle bus trace of each
// instruction from its byte count and wait counts, then compares cycle by cycle.
module tb_core_fetch_seq;
  import core_pkg::*;

  localparam int RND = 2;
  // strobe vector order: {ale, rd_n, enb_c, enb_d, enbrr, enbwr, pc_inc, halted}
  localparam logic [7:0] S_IDLE  = 8'b0100_0000;
  localparam logic [7:0] S_ALE   = 8'b1100_0000;
  localparam logic [7:0] S_RD    = 8'b0000_0000;
  localparam logic [7:0] S_FETCH = 8'b0010_0010;
  localparam logic [7:0] S_DATA  = 8'b0001_0010;
  localparam logic [7:0] S_RR    = 8'b0100_1000;
  localparam logic [7:0] S_WR    = 8'b0100_1100;
  localparam logic [7:0] S_HALT  = 8'b0100_0001;

  typedef struct {
    logic [3:0] st;
    logic [7:0] strb;
    int         rdy;
    int         ni;
    int         ih;
  } exp_t;

  typedef struct packed {
    logic [3:0]  st;
    logic [7:0]  strb;
    logic [15:0] addr;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic        need_imm = 1'b0;
  logic        is_halt = 1'b0;
  logic [15:0] addr;
  logic        ale, rd_n, enb_c, enb_d, enbrr, enbwr, pc_inc, halted;
  logic [3:0]  state;

  int          total = 0;
  int          bad = 0;
  logic [15:0] pc_model = 16'h0000;
  logic [15:0] addr_model = 16'h0000;
  exp_t        exp_q[$];
  obs_t        obs_q[$];
  logic [15:0] eaddr_q[$];

  core_fetch_seq #(.DATASIZE(8), .ADDRSIZE(16)) dut (
    .clk(clk), .rst(rst), .ready(ready), .pc(pc),
    .need_imm(need_imm), .is_halt(is_halt), .addr(addr),
    .ale(ale), .rd_n(rd_n), .enb_c(enb_c), .enb_d(enb_d),
    .enbrr(enbrr), .enbwr(enbwr), .pc_inc(pc_inc), .halted(halted),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] strobes_now();
    return {ale, rd_n, enb_c, enb_d, enbrr, enbwr, pc_inc, halted};
  endfunction

  function automatic void push(logic [3:0] st, logic [7:0] strb, int rdy, int ni, int ih);
    exp_t e;
    e.st = st; e.strb = strb; e.rdy = rdy; e.ni = ni; e.ih = ih;
    exp_q.push_back(e);
  endfunction

  // One bus read: T1, T2, w wait cycles, T3. ready rises in the last T2/TW.
  function automatic void add_bus(logic [3:0] t1, logic [3:0] t2, logic [3:0] tw,
                                  logic [3:0] t3, logic [7:0] s3, int w);
    push(t1, S_ALE, RND, RND, RND);
    push(t2, S_RD, (w == 0) ? 1 : 0, RND, RND);
    for (int i = 0; i < w; i++) push(tw, S_RD, (i == w - 1) ? 1 : 0, RND, RND);
    push(t3, s3, RND, RND, RND);
  endfunction

  function automatic void add_instr(bit imm, int w1, int w2);
    add_bus(OF_T1, OF_T2, OF_TW, OF_T3, S_FETCH, w1);
    push(OF_T4, S_IDLE, RND, imm ? 1 : 0, 0);
    if (imm) add_bus(MR_T1, MR_T2, MR_TW, MR_T3, S_DATA, w2);
    push(EX_RR, S_RR, RND, RND, RND);
    push(EX_WR, S_WR, RND, RND, RND);
  endfunction

  // Drives the trace cycle by cycle, acting as the downstream PC, and records
  // what the DUT shows plus the modelled address. No comparisons here.
  task automatic play(bit jump);
    obs_t o;
    obs_q.delete();
    eaddr_q.delete();
    foreach (exp_q[i]) begin
      @(posedge clk); #1;
      if (exp_q[i].st == 4'(OF_T1) || exp_q[i].st == 4'(MR_T1)) addr_model = pc_model;
      eaddr_q.push_back(addr_model);
      o.st = state; o.strb = strobes_now(); o.addr = addr;
      obs_q.push_back(o);
      if (exp_q[i].strb[1]) pc_model = pc_model + 16'd1;
      if (jump && exp_q[i].st == 4'(EX_WR)) pc_model = 16'($urandom);
      pc       = pc_model;
      ready    = (exp_q[i].rdy == RND) ? 1'($urandom) : 1'(exp_q[i].rdy);
      need_imm = (exp_q[i].ni == RND) ? 1'($urandom) : 1'(exp_q[i].ni);
      is_halt  = (exp_q[i].ih == RND) ? 1'($urandom) : 1'(exp_q[i].ih);
    end
  endtask

  task automatic test_reset;
    int n_c, n_inc;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      total++;
      if (state !== 4'(RESET) || strobes_now() !== S_IDLE) begin
        bad++;
        $display("FAIL reset_outputs: state=%0d strobes=%b, expected state=%0d strobes=%b",
                 state, strobes_now(), RESET, S_IDLE);
      end
      total++;
      if (addr !== 16'h0000) begin
        bad++;
        $display("FAIL reset_addr: addr=%h, expected 0000", addr);
      end
    end
    @(negedge clk); rst = 1'b0;
    pc_model = 16'h0000; addr_model = 16'h0000;
    exp_q.delete();
    add_instr(0, 0, 0);
    play(0);
    n_c = 0; n_inc = 0;
    foreach (exp_q[i]) begin
      total++;
      if (obs_q[i].st !== exp_q[i].st || obs_q[i].strb !== exp_q[i].strb) begin
        bad++;
        $display("FAIL first_fetch cyc%0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                 i, obs_q[i].st, obs_q[i].strb, exp_q[i].st, exp_q[i].strb);
      end
      total++;
      if (obs_q[i].addr !== eaddr_q[i]) begin
        bad++;
        $display("FAIL first_fetch_addr cyc%0d: addr=%h, expected %h", i, obs_q[i].addr, eaddr_q[i]);
      end
      n_c += int'(obs_q[i].strb[5]);
      n_inc += int'(obs_q[i].strb[1]);
    end
    total++;
    if (n_c != 1 || n_inc != 1) begin
      bad++;
      $display("FAIL first_fetch_counts: enb_c=%0d pc_inc=%0d, expected 1 and 1", n_c, n_inc);
    end
  endtask

  task automatic test_one_byte;
    int first, second, n_rr, n_wr;
    exp_q.delete();
    add_instr(0, 0, 0);
    add_instr(0, 0, 0);
    play(0);
    first = -1; second = -1; n_rr = 0; n_wr = 0;
    foreach (exp_q[i]) begin
      total++;
      if (obs_q[i].st !== exp_q[i].st || obs_q[i].strb !== exp_q[i].strb) begin
        bad++;
        $display("FAIL one_byte cyc%0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                 i, obs_q[i].st, obs_q[i].strb, exp_q[i].st, exp_q[i].strb);
      end
      total++;
      if (obs_q[i].addr !== eaddr_q[i]) begin
        bad++;
        $display("FAIL one_byte_addr cyc%0d: addr=%h, expected %h", i, obs_q[i].addr, eaddr_q[i]);
      end
      if (obs_q[i].strb[7] && obs_q[i].st == 4'(OF_T1)) begin
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      n_rr += int'(obs_q[i].strb[3]);
      n_wr += int'(obs_q[i].strb[2]);
    end
    total++;
    if (second - first != 6) begin
      bad++;
      $display("FAIL one_byte_latency: %0d clocks, expected 6", second - first);
    end
    total++;
    if (n_rr != 4 || n_wr != 2) begin
      bad++;
      $display("FAIL one_byte_exec: enbrr=%0d enbwr=%0d cycles, expected 4 and 2", n_rr, n_wr);
    end
  endtask

  task automatic test_two_byte;
    int first, second, n_inc, n_d;
    logic [15:0] mr_addr;
    pc_model = 16'h0010; pc = pc_model;
    exp_q.delete();
    add_instr(1, 0, 0);
    add_instr(0, 0, 0);
    play(0);
    first = -1; second = -1; n_inc = 0; n_d = 0; mr_addr = 16'hxxxx;
    foreach (exp_q[i]) begin
      total++;
      if (obs_q[i].st !== exp_q[i].st || obs_q[i].strb !== exp_q[i].strb) begin
        bad++;
        $display("FAIL two_byte cyc%0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                 i, obs_q[i].st, obs_q[i].strb, exp_q[i].st, exp_q[i].strb);
      end
      total++;
      if (obs_q[i].addr !== eaddr_q[i]) begin
        bad++;
        $display("FAIL two_byte_addr cyc%0d: addr=%h, expected %h", i, obs_q[i].addr, eaddr_q[i]);
      end
      if (obs_q[i].strb[7] && obs_q[i].st == 4'(OF_T1)) begin
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      if (i < 9) begin
        n_inc += int'(obs_q[i].strb[1]);
        n_d += int'(obs_q[i].strb[4]);
      end
      if (obs_q[i].st == 4'(MR_T1)) mr_addr = obs_q[i].addr;
    end
    total++;
    if (second - first != 9) begin
      bad++;
      $display("FAIL two_byte_latency: %0d clocks, expected 9", second - first);
    end
    total++;
    if (n_inc != 2 || n_d != 1) begin
      bad++;
      $display("FAIL two_byte_counts: pc_inc=%0d enb_d=%0d, expected 2 and 1", n_inc, n_d);
    end
    total++;
    if (mr_addr !== 16'h0011) begin
      bad++;
      $display("FAIL two_byte_mr_addr: addr=%h, expected 0011", mr_addr);
    end
  endtask

  task automatic test_wait;
    int first, second, n_tw, n_tw_inc;
    exp_q.delete();
    add_instr(0, 3, 0);
    add_instr(0, 0, 0);
    play(0);
    first = -1; second = -1; n_tw = 0; n_tw_inc = 0;
    foreach (exp_q[i]) begin
      total++;
      if (obs_q[i].st !== exp_q[i].st || obs_q[i].strb !== exp_q[i].strb) begin
        bad++;
        $display("FAIL wait cyc%0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                 i, obs_q[i].st, obs_q[i].strb, exp_q[i].st, exp_q[i].strb);
      end
      total++;
      if (obs_q[i].addr !== eaddr_q[i]) begin
        bad++;
        $display("FAIL wait_addr cyc%0d: addr=%h, expected %h", i, obs_q[i].addr, eaddr_q[i]);
      end
      if (obs_q[i].strb[7] && obs_q[i].st == 4'(OF_T1)) begin
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      if (obs_q[i].st == 4'(OF_TW)) begin
        n_tw++;
        n_tw_inc += int'(obs_q[i].strb[1]);
      end
    end
    total++;
    if (second - first != 9 || n_tw != 3 || n_tw_inc != 0) begin
      bad++;
      $display("FAIL wait_timing: latency=%0d tw=%0d tw_pc_inc=%0d, expected 9, 3, 0",
               second - first, n_tw, n_tw_inc);
    end
  endtask

  task automatic test_halt_priority;
    exp_q.delete();
    add_bus(OF_T1, OF_T2, OF_TW, OF_T3, S_FETCH, 0);
    push(OF_T4, S_IDLE, RND, 1, 1);
    for (int k = 0; k < 20; k++) push(HALT, S_HALT, RND, RND, RND);
    play(0);
    foreach (exp_q[i]) begin
      total++;
      if (obs_q[i].st !== exp_q[i].st || obs_q[i].strb !== exp_q[i].strb) begin
        bad++;
        $display("FAIL halt cyc%0d: state=%0d strobes=%b, expected state=%0d strobes=%b",
                 i, obs_q[i].st, obs_q[i].strb, exp_q[i].st, exp_q[i].strb);
      end
      total++;
      if (obs_q[i].addr !== eaddr_q[i]) begin
        bad++;
        $display("FAIL halt_addr cyc%0d: addr=%h, expected %h", i, obs_q[i].addr, eaddr_q[i]);
      end
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (state !== 4'(RESET) || strobes_now() !== S_IDLE || addr !== 16'h0000) begin
      bad++;
      $display("FAIL halt_reset_async: state=%0d strobes=%b addr=%h, expected %0d %b 0000",
               state, strobes_now(), addr, RESET, S_IDLE);
    end
    @(posedge clk); #1;
    total++;
    if (state !== 4'(RESET)) begin
      bad++;
      $display("FAIL halt_reset_held: state=%0d, expected %0d", state, RESET);
    end
    @(negedge clk); rst = 1'b0;
    addr_model = 16'h0000;
    exp_q.delete();
    add_instr(0, 0, 0);
    play(0);
    foreach (exp_q[i]) begin
      total++;
      if (obs_q[i].st !== exp_q[i].st || obs_q[i].strb !== exp_q[i].strb || obs_q[i].addr !== eaddr_q[i]) begin
        bad++;
        $display("FAIL halt_restart cyc%0d: state=%0d strobes=%b addr=%h, expected %0d %b %h",
                 i, obs_q[i].st, obs_q[i].strb, obs_q[i].addr, exp_q[i].st, exp_q[i].strb, eaddr_q[i]);
      end
    end
  endtask

  task automatic test_async_reset;
    int k;
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.delete();
      if (pass == 0) begin
        add_instr(0, 0, 0);
      end else begin
        add_instr(1, 0, 4);
        k = 0;
        while (exp_q[k].st != 4'(MR_TW)) k++;
        while (exp_q.size() > k + 2) void'(exp_q.pop_back());
      end
      play(0);
      foreach (exp_q[i]) begin
        total++;
        if (obs_q[i].st !== exp_q[i].st || obs_q[i].strb !== exp_q[i].strb || obs_q[i].addr !== eaddr_q[i]) begin
          bad++;
          $display("FAIL async_pre%0d cyc%0d: state=%0d strobes=%b addr=%h, expected %0d %b %h",
                   pass, i, obs_q[i].st, obs_q[i].strb, obs_q[i].addr, exp_q[i].st, exp_q[i].strb, eaddr_q[i]);
        end
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (state !== 4'(RESET) || strobes_now() !== S_IDLE || addr !== 16'h0000) begin
        bad++;
        $display("FAIL async_reset%0d: state=%0d strobes=%b addr=%h, expected %0d %b 0000",
                 pass, state, strobes_now(), addr, RESET, S_IDLE);
      end
      @(negedge clk); rst = 1'b0;
      addr_model = 16'h0000;
      pc_model = 16'($urandom); pc = pc_model;
      exp_q.delete();
      add_instr(0, 0, 0);
      play(0);
      foreach (exp_q[i]) begin
        total++;
        if (obs_q[i].st !== exp_q[i].st || obs_q[i].strb !== exp_q[i].strb || obs_q[i].addr !== eaddr_q[i]) begin
          bad++;
          $display("FAIL async_restart%0d cyc%0d: state=%0d strobes=%b addr=%h, expected %0d %b %h",
                   pass, i, obs_q[i].st, obs_q[i].strb, obs_q[i].addr, exp_q[i].st, exp_q[i].strb, eaddr_q[i]);
        end
      end
    end
  endtask

  task automatic test_wrap;
    logic [15:0] mr_addr;
    pc_model = 16'hFFFF; pc = pc_model;
    exp_q.delete();
    add_instr(1, 1, 0);
    play(0);
    mr_addr = 16'hxxxx;
    foreach (exp_q[i]) begin
      total++;
      if (obs_q[i].st !== exp_q[i].st || obs_q[i].strb !== exp_q[i].strb || obs_q[i].addr !== eaddr_q[i]) begin
        bad++;
        $display("FAIL wrap cyc%0d: state=%0d strobes=%b addr=%h, expected %0d %b %h",
                 i, obs_q[i].st, obs_q[i].strb, obs_q[i].addr, exp_q[i].st, exp_q[i].strb, eaddr_q[i]);
      end
      if (obs_q[i].st == 4'(MR_T1)) mr_addr = obs_q[i].addr;
    end
    total++;
    if (mr_addr !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_mr_addr: addr=%h, expected 0000", mr_addr);
    end
  endtask

  task automatic test_random;
    exp_q.delete();
    for (int n = 0; n < 40; n++)
      add_instr(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    play(1);
    foreach (exp_q[i]) begin
      total++;
      if (obs_q[i].st !== exp_q[i].st || obs_q[i].strb !== exp_q[i].strb || obs_q[i].addr !== eaddr_q[i]) begin
        bad++;
        $display("FAIL random cyc%0d: state=%0d strobes=%b addr=%h, expected %0d %b %h",
                 i, obs_q[i].st, obs_q[i].strb, obs_q[i].addr, exp_q[i].st, exp_q[i].strb, eaddr_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_two_byte();
    test_wait();
    test_wrap();
    test_random();
    test_async_reset();
    test_halt_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_fetch_seq.md
Name: core_fetch_seq

Overview:
- Machine-cycle / T-state sequencer for the 8085-style core.
- Sits directly upstream of the ALU/register-file stage:
  - fetches opcode and optional immediate bytes from the external bus;
  - drives that stage's instruction-load, data-load, register-read and register-write strobes;
  - requests PC increments.
- The downstream stage returns decode flags (need_imm, is_halt) and its program counter (pc).

Parameters:
- DATASIZE, 8, width of the data bus.
- ADDRSIZE, 16, width of the address bus and PC.

Ports:
- clk  input  1  core clock, rising-edge.
- rst  input  1  reset; asynchronous, active-high.
- ready  input  1  external memory ready; sampled in T2/TW.
- pc  input  ADDRSIZE  current PC from the ALU/register stage.
- need_imm  input  1  decode flag, valid in OF_T4: instruction needs one immediate byte.
- is_halt  input  1  decode flag, valid in OF_T4: instruction is HLT.
- addr  output  ADDRSIZE  registered bus address.
- ale  output  1  address latch enable.
- rd_n  output  1  read strobe, active-low.
- enb_c  output  1  load instruction register downstream.
- enb_d  output  1  load temp/data register downstream.
- enbrr  output  1  register read enable.
- enbwr  output  1  register write enable.
- pc_inc  output  1  one-cycle PC increment request.
- halted  output  1  sequencer is in HALT.
- state  output  4  current state code, for debug and bench checks.

Behaviour:
- Moore machine; all strobes are decoded from the state register only.
- addr is a register loaded from pc on entry to OF_T1/MR_T1 and held until the next T1.
- Reset (async, any state, mid-cycle included):
  - state=RESET, addr=0;
  - ale=0, rd_n=1, enb_c=enb_d=enbrr=enbwr=0, pc_inc=0, halted=0.
- RESET -> OF_T1 on the first clk edge with rst low.
- States and outputs (unlisted outputs are 0, rd_n=1):
  - OF_T1: ale=1. -> OF_T2.
  - OF_T2: rd_n=0. ready=1 -> OF_T3; ready=0 -> OF_TW.
  - OF_TW: rd_n=0. Stays while ready=0; ready=1 -> OF_T3. No limit on wait count.
  - OF_T3: rd_n=0, enb_c=1, pc_inc=1. -> OF_T4.
  - OF_T4: no strobes; decode settles. Next state:
    - is_halt=1 -> HALT (priority over need_imm);
    - else need_imm=1 -> MR_T1;
    - else -> EX_RR.
  - MR_T1: ale=1, addr loads the already-incremented pc. -> MR_T2.
  - MR_T2 / MR_TW: same ready rules as the OF equivalents.
  - MR_T3: rd_n=0, enb_d=1, pc_inc=1. -> EX_RR.
  - EX_RR: enbrr=1. -> EX_WR.
  - EX_WR: enbrr=1, enbwr=1. -> OF_T1.
  - HALT: halted=1, no strobes. Exited only by rst.
- Latency with ready=1 throughout:
  - 1-byte instruction = 6 clocks, OF_T1 to OF_T1;
  - 2-byte instruction = 9 clocks.
  - Each wait cycle adds 1 clock.
- Counts per instruction:
  - pc_inc pulses exactly once per fetched byte (1 or 2 per instruction), never in TW;
  - enb_c and enb_d each pulse for exactly one cycle per byte.
- need_imm and is_halt are ignored outside OF_T4; ready is ignored outside T2/TW.
- addr wraps naturally, since it simply follows pc (FFFF then 0000).
- Undefined state codes recover to RESET on the next clock.

Decomposition:
- Shared package core_pkg holds:
  - state encoding localparams: RESET, OF_T1..OF_T4, OF_TW, MR_T1..MR_T3, MR_TW, EX_RR, EX_WR, HALT;
  - DATASIZE and ADDRSIZE defaults.
- No sub-module is warranted: one state register plus an address register, with output decode in the same module.
- The upper-level core instantiates core_fetch_seq and alureg side by side.

Test Plan:
- Reset and first fetch: hold rst for 2 clocks with pc=0000, ready=1, need_imm=0 -> all outputs at reset values during rst; first clock after release enters OF_T1 with ale=1, addr=0000; enb_c at OF_T3, one pc_inc.
- 1-byte instruction (XRA A): ready=1, need_imm=0 -> enbrr high for 2 cycles, enbwr for 1 (EX_WR); next ale exactly 6 clocks after the previous one.
- 2-byte instruction (MVI A,AAh): need_imm=1 in OF_T4, pc stepping 0010 then 0011 -> MR_T1 addr=0011; enb_d in MR_T3; two pc_inc pulses total; 9-clock instruction.
- Wait states: ready=0 for 3 clocks during OF_T2 -> rd_n stays 0 through 3 TW cycles; enb_c only after ready rises; instruction takes 9 clocks; no pc_inc during TW.
- Halt priority: is_halt=1 and need_imm=1 together in OF_T4 -> HALT, halted=1, no further ale or strobes for 20 clocks; rst pulse -> RESET then OF_T1.
- Async reset mid-operation: assert rst between clock edges during EX_WR and during MR_TW -> outputs return to reset values immediately, without waiting for a clock edge; clean restart at OF_T1.
